// File: rtl/axicb_grant_scheduler_if.sv
// Handshake bundle between a crossbar slave port's grant scheduler and its surroundings.
// The master side is the scheduler; the slave side is the requesters, arbiter and switch.
interface axicb_grant_scheduler_if #(
    parameter int REQ_NB = 4
);
    logic [REQ_NB-1:0] req;
    logic [REQ_NB-1:0] arb_req;
    logic              arb_en;
    logic [REQ_NB-1:0] arb_grant;
    logic [REQ_NB-1:0] sel;
    logic              sel_valid;
    logic              fwd_ready;
    logic              beat_last;
    logic [REQ_NB-1:0] done;
    logic [REQ_NB-1:0] full;

    modport master (
        input  req, arb_grant, fwd_ready, beat_last, done,
        output arb_req, arb_en, sel, sel_valid, full
    );

    modport slave (
        output req, arb_grant, fwd_ready, beat_last, done,
        input  arb_req, arb_en, sel, sel_valid, full
    );
endinterface

// File: rtl/axicb_grant_scheduler.sv
// Locks one requester onto a shared crossbar slave port through address (and data) phase,
// and throttles each requester against its outstanding-transaction limit.
module axicb_grant_scheduler #(
    parameter int REQ_NB     = 4,
    parameter int MAX_OSTDG  = 4,
    parameter bit DATA_PHASE = 1'b1
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    srst,
    axicb_grant_scheduler_if.master bus
);
    localparam int CW = $clog2(MAX_OSTDG + 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state_reg;
    logic [REQ_NB-1:0] sel_reg;
    logic              sel_valid_reg;
    logic [CW-1:0]     cnt_reg [REQ_NB];

    logic [REQ_NB-1:0] full;
    logic [REQ_NB-1:0] inc;
    logic [REQ_NB-1:0] grant_low;
    logic              sel_req;
    logic              accept;

    genvar gi;
    generate
        for (gi = 0; gi < REQ_NB; gi++) begin : g_req
            assign full[gi] = (cnt_reg[gi] == CW'(MAX_OSTDG));
            assign inc[gi]  = accept & sel_reg[gi];
        end
    endgenerate

    // A multi-bit grant is an arbiter fault; the lowest set bit wins so sel stays one-hot.
    assign grant_low = bus.arb_grant & (~bus.arb_grant + REQ_NB'(1));
    assign sel_req   = |(bus.req & sel_reg);
    assign accept    = (state_reg == ADDR) && bus.fwd_ready && sel_req;

    assign bus.arb_req   = bus.req & ~full;
    assign bus.arb_en    = (state_reg == IDLE) && (|bus.arb_req);
    assign bus.sel       = sel_reg;
    assign bus.sel_valid = sel_valid_reg;
    assign bus.full      = full;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg     <= IDLE;
            sel_reg       <= '0;
            sel_valid_reg <= 1'b0;
        end else if (srst) begin
            state_reg     <= IDLE;
            sel_reg       <= '0;
            sel_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|bus.arb_grant) begin
                        sel_reg       <= grant_low;
                        sel_valid_reg <= 1'b1;
                        state_reg     <= ADDR;
                    end
                end
                ADDR: begin
                    // A selected requester dropping its valid aborts the lock without counting.
                    if (!sel_req || (bus.fwd_ready && !DATA_PHASE)) begin
                        sel_reg       <= '0;
                        sel_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end else if (bus.fwd_ready) begin
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (bus.beat_last) begin
                        sel_reg       <= '0;
                        sel_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    sel_reg       <= '0;
                    sel_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    // Simultaneous accept and completion on one requester cancel out.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < REQ_NB; i++) cnt_reg[i] <= '0;
        end else if (srst) begin
            for (int i = 0; i < REQ_NB; i++) cnt_reg[i] <= '0;
        end else begin
            for (int i = 0; i < REQ_NB; i++) begin
                if (inc[i] && !bus.done[i]) begin
                    if (!full[i]) cnt_reg[i] <= cnt_reg[i] + CW'(1);
                end else if (!inc[i] && bus.done[i] && (cnt_reg[i] != '0)) begin
                    cnt_reg[i] <= cnt_reg[i] - CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_axicb_grant_scheduler.sv
// Directed bench: instance a (MAX_OSTDG=4, data phase) behind a round-robin arbiter model,
// instance b (MAX_OSTDG=2, address only) behind a fixed-priority arbiter model.
module tb_axicb_grant_scheduler;
    logic aclk = 1'b0;
    logic areset;
    logic srst;

    axicb_grant_scheduler_if #(.REQ_NB(4)) ia ();
    axicb_grant_scheduler_if #(.REQ_NB(4)) ib ();

    axicb_grant_scheduler #(.REQ_NB(4), .MAX_OSTDG(4), .DATA_PHASE(1'b1)) dut_a (
        .aclk(aclk), .areset(areset), .srst(srst), .bus(ia.master)
    );
    axicb_grant_scheduler #(.REQ_NB(4), .MAX_OSTDG(2), .DATA_PHASE(1'b0)) dut_b (
        .aclk(aclk), .areset(areset), .srst(srst), .bus(ib.master)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] exp_a[$];
    logic [3:0] exp_b[$];

    // Round-robin arbiter model for instance a.
    logic [1:0] rr_ptr;
    logic [1:0] rr_idx;
    logic [3:0] rr_g;
    always_comb begin
        rr_g   = '0;
        rr_idx = '0;
        for (int k = 0; k < 4; k++) begin
            rr_idx = rr_ptr + 2'(k);
            if (rr_g == '0 && ia.arb_req[rr_idx]) rr_g[rr_idx] = 1'b1;
        end
    end
    assign ia.arb_grant = rr_g;
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) rr_ptr <= '0;
        else if (ia.arb_en && rr_g != '0)
            for (int k = 0; k < 4; k++) if (rr_g[k]) rr_ptr <= 2'(k + 1);
    end

    assign ib.arb_grant = ib.arb_req & (~ib.arb_req + 4'd1);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req_v);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Scoreboard monitor: every new lock (sel_valid rising) must match the queued selection.
    logic pa = 1'b0;
    logic pb = 1'b0;
    logic [3:0] e_sel;
    initial begin
        forever begin
            @(negedge aclk);
            if (ia.sel_valid && !pa) begin
                n_cmp++;
                if (exp_a.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_a_grant: got sel %b, required no grant", ia.sel);
                end else begin
                    e_sel = exp_a.pop_front();
                    if (ia.sel !== e_sel) begin
                        n_err++;
                        $display("FAIL sb_a_grant: got sel %b, required %b", ia.sel, e_sel);
                    end else $display("ok   sb_a_grant: sel %b", ia.sel);
                end
            end
            if (ib.sel_valid && !pb) begin
                n_cmp++;
                if (exp_b.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_b_grant: got sel %b, required no grant", ib.sel);
                end else begin
                    e_sel = exp_b.pop_front();
                    if (ib.sel !== e_sel) begin
                        n_err++;
                        $display("FAIL sb_b_grant: got sel %b, required %b", ib.sel, e_sel);
                    end else $display("ok   sb_b_grant: sel %b", ib.sel);
                end
            end
            pa = ia.sel_valid;
            pb = ib.sel_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    logic [3:0] seq4 [4];

    initial begin
        areset = 1'b1;
        srst   = 1'b0;
        ia.req = '0; ia.fwd_ready = 1'b0; ia.beat_last = 1'b0; ia.done = '0;
        ib.req = '0; ib.fwd_ready = 1'b0; ib.beat_last = 1'b0; ib.done = '0;
        repeat (2) step();
        areset = 1'b0;
        step();

        // Reset state
        chk("rst_sel", 32'(ia.sel), 0);
        chk("rst_sel_valid", 32'(ia.sel_valid), 0);
        chk("rst_full", 32'(ia.full), 0);
        chk("rst_arb_en", 32'(ia.arb_en), 0);

        // 1: single grant, address then data phase
        ia.req = 4'b0010;
        exp_a.push_back(4'b0010);
        #1;
        chk("t1_arb_req", 32'(ia.arb_req), 32'h2);
        chk("t1_arb_en", 32'(ia.arb_en), 1);
        step();
        chk("t1_sel_valid", 32'(ia.sel_valid), 1);
        ia.fwd_ready = 1'b1;
        step();
        ia.fwd_ready = 1'b0;
        ia.req = '0;
        chk("t1_cnt1", 32'(dut_a.cnt_reg[1]), 1);
        chk("t1_data_hold", 32'(ia.sel), 32'h2);
        ia.beat_last = 1'b1;
        step();
        ia.beat_last = 1'b0;
        chk("t1_release_sel", 32'(ia.sel), 0);
        chk("t1_release_valid", 32'(ia.sel_valid), 0);

        // 3: accept and done collide on requester 2; done on an empty counter
        ia.req = 4'b0100;
        exp_a.push_back(4'b0100);
        step();
        ia.fwd_ready = 1'b1;
        step();
        ia.fwd_ready = 1'b0;
        ia.beat_last = 1'b1;
        step();
        ia.beat_last = 1'b0;
        chk("t3_cnt2_pre", 32'(dut_a.cnt_reg[2]), 1);
        exp_a.push_back(4'b0100);
        step();
        ia.fwd_ready = 1'b1;
        ia.done = 4'b1100;
        step();
        ia.fwd_ready = 1'b0;
        ia.done = '0;
        ia.req = '0;
        chk("t3_cnt2_same", 32'(dut_a.cnt_reg[2]), 1);
        chk("t3_cnt3_sat", 32'(dut_a.cnt_reg[3]), 0);
        ia.beat_last = 1'b1;
        step();
        ia.beat_last = 1'b0;

        // 4: all requesting; beat_last in ADDR ignored, arb_en only in IDLE
        seq4[0] = 4'b1000; seq4[1] = 4'b0001; seq4[2] = 4'b0010; seq4[3] = 4'b0100;
        ia.req = 4'b1111;
        for (int t = 0; t < 4; t++) begin
            #1;
            chk("t4_en_idle", 32'(ia.arb_en), 1);
            exp_a.push_back(seq4[t]);
            step();
            chk("t4_en_addr", 32'(ia.arb_en), 0);
            ia.beat_last = 1'b1;
            ia.fwd_ready = 1'b1;
            step();
            ia.beat_last = 1'b0;
            ia.fwd_ready = 1'b0;
            chk("t4_hold_after_addr", 32'(ia.sel), 32'(seq4[t]));
            step();
            chk("t4_en_data", 32'(ia.arb_en), 0);
            chk("t4_hold_data", 32'(ia.sel_valid), 1);
            ia.beat_last = 1'b1;
            step();
            ia.beat_last = 1'b0;
            if (t == 3) ia.req = '0;
            chk("t4_release", 32'(ia.sel_valid), 0);
        end
        chk("t4_cnt1", 32'(dut_a.cnt_reg[1]), 2);

        // 5: selected requester drops valid in ADDR
        ia.req = 4'b0001;
        exp_a.push_back(4'b0001);
        step();
        ia.req = '0;
        step();
        chk("t5_sel", 32'(ia.sel), 0);
        chk("t5_sel_valid", 32'(ia.sel_valid), 0);
        chk("t5_cnt0", 32'(dut_a.cnt_reg[0]), 1);

        // 6: asynchronous reset in DATA with cnt[1]=3
        ia.req = 4'b0010;
        exp_a.push_back(4'b0010);
        step();
        ia.fwd_ready = 1'b1;
        step();
        ia.fwd_ready = 1'b0;
        ia.req = '0;
        chk("t6_cnt1_pre", 32'(dut_a.cnt_reg[1]), 3);
        #2 areset = 1'b1;
        #1;
        chk("t6_async_sel", 32'(ia.sel), 0);
        chk("t6_async_valid", 32'(ia.sel_valid), 0);
        chk("t6_async_cnt1", 32'(dut_a.cnt_reg[1]), 0);
        chk("t6_async_full", 32'(ia.full), 0);
        step();
        areset = 1'b0;
        ia.req = 4'b0100;
        exp_a.push_back(4'b0100);
        step();
        ia.fwd_ready = 1'b1;
        step();
        ia.fwd_ready = 1'b0;
        ia.req = '0;
        chk("t6_resume_cnt2", 32'(dut_a.cnt_reg[2]), 1);
        ia.beat_last = 1'b1;
        step();
        ia.beat_last = 1'b0;

        // 2: outstanding limit on instance b (MAX_OSTDG=2, address only)
        ib.req = 4'b0001;
        ib.fwd_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            exp_b.push_back(4'b0001);
            step();
            chk("t2_lock", 32'(ib.sel_valid), 1);
            step();
            chk("t2_release", 32'(ib.sel_valid), 0);
        end
        chk("t2_full", 32'(ib.full), 1);
        chk("t2_arb_req_masked", 32'(ib.arb_req), 0);
        chk("t2_arb_en_off", 32'(ib.arb_en), 0);
        step();
        chk("t2_no_grant", 32'(ib.sel_valid), 0);
        ib.done = 4'b0001;
        step();
        ib.done = '0;
        chk("t2_full_clear", 32'(ib.full), 0);
        chk("t2_arb_req_back", 32'(ib.arb_req), 1);
        exp_b.push_back(4'b0001);
        step();
        step();
        ib.req = '0;
        ib.fwd_ready = 1'b0;
        chk("t2_full_again", 32'(ib.full), 1);
        srst = 1'b1;
        step();
        srst = 1'b0;
        chk("srst_full", 32'(ib.full), 0);

        repeat (2) step();
        chk("sb_a_drain", 32'(exp_a.size()), 0);
        chk("sb_b_drain", 32'(exp_b.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
